wiener_mac_engine: RTL and testbench

- Fixed-point matrix–vector multiply-accumulate engine for the Wiener decoder.
- Computes up to four row dot products. Each product is a signed 8-bit weight row (weight RAM) times a shared signed 16-bit feature vector (data RAM).
- Results are packed into one 64-bit output word.
- Sits between the feature/weight loader (host write ports) and the downstream decode output stage.

---
 rtl/wiener_mac_engine_pkg.sv | 29 ++
 rtl/wiener_mac_engine_mult.sv | 29 ++
 rtl/wiener_mac_engine_ram.sv | 38 +++
 rtl/wiener_mac_engine.sv | 156 +++++++++++++++
 tb/tb_wiener_mac_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/wiener_mac_engine_pkg.sv
// Shared definitions for the Wiener decoder MAC engine: FSM encoding,
// derived address widths and the result packing slice offsets.
package wiener_mac_engine_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_START,
        S_READ_DATA,
        S_WAIT_READ,
        S_MULT_CAL,
        S_WAIT_CAL,
        S_ADD_CAL,
        S_DET,
        S_FINISH
    } state_e;

    // Rows 0-1 keep the low half of the sum, rows 2-3 a window shifted up a byte.
    localparam int LO_SLICE_OFS = 0;
    localparam int HI_SLICE_OFS = 8;

    function automatic int addr_wid(input int col_num, input int row_num);
        return $clog2(col_num * row_num) + 1;
    endfunction

    function automatic int col_w(input int col_num);
        return $clog2(col_num) + 1;
    endfunction

endpackage

// File: rtl/wiener_mac_engine_mult.sv
// Pipelined signed multiplier: input register, one product stage, output
// register, so a result appears three cycles after its operands.
module pmi_mult #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);
    logic signed [W-1:0]   a_q, b_q;
    logic signed [2*W-1:0] p1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            p1_q <= '0;
            p_o  <= '0;
        end else begin
            a_q  <= a_i;
            b_q  <= b_i;
            p1_q <= a_q * b_q;
            p_o  <= p1_q;
        end
    end

endmodule

// File: rtl/wiener_mac_engine_ram.sv
// Generic simple dual-port RAM with registered address and registered output
// (2-cycle read latency); read-during-write returns the old word.
module pmi_ram_dp #(
    parameter int    DW        = 8,
    parameter int    DEPTH     = 256,
    parameter int    AW        = 9,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);
    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_addr_q;

    // Contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en_i && (int'(wr_addr_i) < DEPTH))
            mem_q[wr_addr_i[IW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_data_o <= '0;
        end else begin
            rd_addr_q <= rd_addr_i;
            rd_data_o <= (int'(rd_addr_q) < DEPTH) ? mem_q[rd_addr_q[IW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/wiener_mac_engine.sv
// Matrix-vector MAC for the Wiener decoder: up to four rows of signed 8-bit
// weights dotted with a shared 16-bit feature vector, packed into one word.
module wiener_mac_engine
    import wiener_mac_engine_pkg::*;
#(
    parameter int    WIDTH     = 16,
    parameter int    COL_NUM   = 128,
    parameter int    ROW_NUM   = 2,
    parameter string INIT_FILE = "",
    localparam int   ADDR_WID  = addr_wid(COL_NUM, ROW_NUM),
    localparam int   COL_W     = col_w(COL_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WID-1:0]   wr_addr,
    input  logic                  ram_wr_en,
    input  logic [WIDTH-1:0]      ram_data_in,
    input  logic                  rd_para,
    input  logic [1:0]            rd_bank,
    input  logic [7:0]            rd_wiener,
    input  logic [COL_W-1:0]      wr_data_addr,
    input  logic                  ram_wr_data_en,
    input  logic [WIDTH-1:0]      ram_data_wr_in,
    output logic [2*WIDTH-1:0]    DSP_ADD_DATA_o,
    output logic [4*WIDTH-1:0]    Wiener_data,
    output logic                  Wiener_data_v,
    output logic                  finish_cal_o,
    output logic [WIDTH/2-1:0]    ram_data_out_o,
    output logic                  data_wr_v_o
);
    localparam int HW = WIDTH / 2;

    state_e                     state_q;
    logic [COL_W-1:0]           col_cnt_q;
    logic [1:0]                 row_cnt_q;
    logic [2*WIDTH-1:0]         acc_q;
    logic [2:0]                 vld_pipe_q;
    logic [4*WIDTH-1:0]         wiener_q;
    logic                       wiener_v_q, finish_q, data_wr_v_q;

    logic [ADDR_WID-1:0]        comp_addr, w_rd_addr;
    logic [HW-1:0]              w_rd;
    logic [WIDTH-1:0]           d_rd, slot_val;
    logic signed [WIDTH-1:0]    w_ext;
    logic signed [2*WIDTH-1:0]  prod;
    logic                       unused_bits;

    assign unused_bits = ^{ram_data_in[WIDTH-1:HW], rd_wiener[7:6]};

    assign comp_addr = ADDR_WID'(row_cnt_q) * ADDR_WID'(COL_NUM) + ADDR_WID'(col_cnt_q);
    // Debug readback only steals the port while the engine is idle.
    assign w_rd_addr = (state_q == S_INIT && rd_para)
                     ? ADDR_WID'({rd_bank, rd_wiener[5:0]}) : comp_addr;

    pmi_ram_dp #(.DW(HW), .DEPTH(COL_NUM*ROW_NUM), .AW(ADDR_WID), .INIT_FILE(INIT_FILE)) u_wram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (ram_data_in[HW-1:0]),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd)
    );

    pmi_ram_dp #(.DW(WIDTH), .DEPTH(COL_NUM), .AW(COL_W), .INIT_FILE("")) u_dram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ram_wr_data_en),
        .wr_addr_i (wr_data_addr),
        .wr_data_i (ram_data_wr_in),
        .rd_addr_i (col_cnt_q),
        .rd_data_o (d_rd)
    );

    assign w_ext = {{(WIDTH-HW){w_rd[HW-1]}}, w_rd};

    pmi_mult #(.W(WIDTH)) u_mult (
        .clk (clk),
        .rst (rst),
        .a_i (w_ext),
        .b_i ($signed(d_rd)),
        .p_o (prod)
    );

    assign slot_val = row_cnt_q[1] ? acc_q[HI_SLICE_OFS +: WIDTH] : acc_q[LO_SLICE_OFS +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            acc_q       <= '0;
            vld_pipe_q  <= '0;
            wiener_q    <= '0;
            wiener_v_q  <= 1'b0;
            finish_q    <= 1'b0;
            data_wr_v_q <= 1'b0;
        end else begin
            // Operands reach the multiplier in MULT_CAL; bit 2 marks the result landing.
            vld_pipe_q <= {vld_pipe_q[1:0], state_q == S_WAIT_READ};
            wiener_v_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    col_cnt_q <= '0;
                    row_cnt_q <= '0;
                    acc_q     <= '0;
                    if (start) state_q <= S_START;
                end
                S_START:     state_q <= S_READ_DATA;
                S_READ_DATA: state_q <= S_WAIT_READ;
                S_WAIT_READ: state_q <= S_MULT_CAL;
                S_MULT_CAL:  state_q <= S_WAIT_CAL;
                S_WAIT_CAL:  if (vld_pipe_q[2]) state_q <= S_ADD_CAL;
                S_ADD_CAL: begin
                    acc_q <= acc_q + prod;
                    if (col_cnt_q < COL_W'(COL_NUM - 1)) begin
                        col_cnt_q <= col_cnt_q + 1'b1;
                        state_q   <= S_START;
                    end else begin
                        col_cnt_q   <= '0;
                        data_wr_v_q <= 1'b1;
                        state_q     <= S_DET;
                    end
                end
                S_DET: begin
                    acc_q       <= '0;
                    data_wr_v_q <= 1'b0;
                    wiener_q[int'(row_cnt_q)*WIDTH +: WIDTH] <= slot_val;
                    if (row_cnt_q < 2'(ROW_NUM - 1)) begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                        state_q   <= S_START;
                    end else begin
                        row_cnt_q  <= '0;
                        finish_q   <= 1'b1;
                        wiener_v_q <= 1'b1;
                        state_q    <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    finish_q <= 1'b0;
                    state_q  <= S_INIT;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign DSP_ADD_DATA_o = acc_q;
    assign Wiener_data    = wiener_q;
    assign Wiener_data_v  = wiener_v_q;
    assign finish_cal_o   = finish_q;
    assign data_wr_v_o    = data_wr_v_q;
    assign ram_data_out_o = w_rd;

endmodule

// File: tb/tb_wiener_mac_engine.sv
// Randomized bench for wiener_mac_engine: a small (4x2) and a full-size
// (128x4) instance checked against a plain-arithmetic dot-product model.
module tb_wiener_mac_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b, wen_a, wen_b, dwen_a, dwen_b;
    logic [9:0]  wr_addr;
    logic [15:0] ram_data_in, ram_data_wr_in;
    logic [7:0]  wr_data_addr;
    logic        rd_para;
    logic [1:0]  rd_bank;
    logic [7:0]  rd_wiener;

    logic [31:0] acc_a, acc_b;
    logic [63:0] wd_a, wd_b;
    logic        wv_a, wv_b, fin_a, fin_b, dv_a, dv_b;
    logic [7:0]  rdo_a, rdo_b;

    logic [7:0]  wa [8];
    logic [15:0] da [4];
    logic [7:0]  wb [512];
    logic [15:0] db [128];
    logic [63:0] mwd_a, mwd_b;
    logic [31:0] first_acc;
    int          n_tests = 0, n_fail = 0;

    wiener_mac_engine #(.WIDTH(16), .COL_NUM(4), .ROW_NUM(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .wr_addr(wr_addr[3:0]), .ram_wr_en(wen_a),
        .ram_data_in(ram_data_in), .rd_para(rd_para), .rd_bank(rd_bank), .rd_wiener(rd_wiener),
        .wr_data_addr(wr_data_addr[2:0]), .ram_wr_data_en(dwen_a), .ram_data_wr_in(ram_data_wr_in),
        .DSP_ADD_DATA_o(acc_a), .Wiener_data(wd_a), .Wiener_data_v(wv_a), .finish_cal_o(fin_a),
        .ram_data_out_o(rdo_a), .data_wr_v_o(dv_a)
    );

    wiener_mac_engine #(.WIDTH(16), .COL_NUM(128), .ROW_NUM(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .wr_addr(wr_addr), .ram_wr_en(wen_b),
        .ram_data_in(ram_data_in), .rd_para(rd_para), .rd_bank(rd_bank), .rd_wiener(rd_wiener),
        .wr_data_addr(wr_data_addr), .ram_wr_data_en(dwen_b), .ram_data_wr_in(ram_data_wr_in),
        .DSP_ADD_DATA_o(acc_b), .Wiener_data(wd_b), .Wiener_data_v(wv_b), .finish_cal_o(fin_b),
        .ram_data_out_o(rdo_b), .data_wr_v_o(dv_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_w(input bit sel, input int addr, input logic [7:0] v);
        @(negedge clk);
        wr_addr     = 10'(addr);
        ram_data_in = {8'($urandom), v};
        if (sel) begin wen_b = 1'b1; wb[addr] = v; end
        else     begin wen_a = 1'b1; wa[addr] = v; end
        @(negedge clk);
        wen_a = 1'b0;
        wen_b = 1'b0;
    endtask

    task automatic put_d(input bit sel, input int addr, input logic [15:0] v);
        @(negedge clk);
        wr_data_addr   = 8'(addr);
        ram_data_wr_in = v;
        if (sel) begin dwen_b = 1'b1; db[addr] = v; end
        else     begin dwen_a = 1'b1; da[addr] = v; end
        @(negedge clk);
        dwen_a = 1'b0;
        dwen_b = 1'b0;
    endtask

    // Reference: exact signed dot product, reduced modulo 2^32.
    function automatic logic [31:0] exp_sum(input bit sel, input int r);
        longint s;
        int     n;
        s = 0;
        n = sel ? 128 : 4;
        for (int c = 0; c < n; c++) begin
            if (sel) s += longint'($signed(wb[r*128+c])) * longint'($signed(db[c]));
            else     s += longint'($signed(wa[r*4+c]))   * longint'($signed(da[c]));
        end
        return s[31:0];
    endfunction

    // One full run: row timing, row sums, packed word, and single pulses.
    task automatic run(input bit sel, input bit poke, input string tag);
        int ncol, nrow, per, rows, vcnt, cyc;
        bit done;
        logic [31:0] s, got;
        ncol = sel ? 128 : 4;
        nrow = sel ? 4 : 2;
        per  = 7*ncol + 1;
        rows = 0; vcnt = 0; cyc = 1; done = 1'b0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        while (!done && cyc < per*nrow + 8) begin
            if (poke) begin
                if (sel) start_b = (cyc >= 10 && cyc < 14);
                else     start_a = (cyc >= 10 && cyc < 14);
            end
            if (sel ? dv_b : dv_a) begin
                s   = exp_sum(sel, rows);
                got = sel ? acc_b : acc_a;
                chk({tag, "_lat"}, 64'(cyc), 64'(per*(rows+1)));
                chk({tag, "_sum"}, 64'(got), 64'(s));
                if (rows == 0) first_acc = got;
                if (sel) mwd_b[rows*16 +: 16] = (rows < 2) ? s[15:0] : s[23:8];
                else     mwd_a[rows*16 +: 16] = (rows < 2) ? s[15:0] : s[23:8];
                rows++;
            end
            if (sel ? wv_b : wv_a) begin
                vcnt++;
                chk({tag, "_wd"}, sel ? wd_b : wd_a, sel ? mwd_b : mwd_a);
                chk({tag, "_wv_row"}, 64'(rows), 64'(nrow));
            end
            if (sel ? fin_b : fin_a) begin
                done = 1'b1;
                chk({tag, "_fin_cyc"}, 64'(cyc), 64'(per*nrow + 1));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_vcnt"}, 64'(vcnt), 64'd1);
        chk({tag, "_rows"}, 64'(rows), 64'(nrow));
    endtask

    task automatic idle_chk(input bit sel, input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (sel ? (dv_b | fin_b | wv_b) : (dv_a | fin_a | wv_a)) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acc"}, 64'(acc_a), 64'd0);
        chk({tag, "_wd"},  wd_a, 64'd0);
        chk({tag, "_flags"}, 64'({wv_a, fin_a, dv_a}), 64'd0);
        chk({tag, "_rdo"}, 64'(rdo_a), 64'd0);
        chk({tag, "_b"}, 64'({acc_b, wv_b, fin_b, dv_b, rdo_b}), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {start_a, start_b, wen_a, wen_b, dwen_a, dwen_b} = '0;
        wr_addr = '0; ram_data_in = '0; wr_data_addr = '0; ram_data_wr_in = '0;
        rd_para = 1'b0; rd_bank = '0; rd_wiener = '0;
        mwd_a = '0; mwd_b = '0; first_acc = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Known vectors: row0 = 1..4, row1 = -1, data 10..40
        for (int i = 0; i < 4; i++) put_w(0, i, 8'(i + 1));
        for (int i = 4; i < 8; i++) put_w(0, i, 8'hFF);
        for (int i = 0; i < 4; i++) put_d(0, i, 16'(10 * (i + 1)));
        run(0, 1'b1, "t1");
        chk("t1_slot0", 64'(wd_a[15:0]), 64'h012C);
        chk("t2_slot1", 64'(wd_a[31:16]), 64'hFF9C);
        chk("t1_row0", 64'(first_acc), 64'd300);
        idle_chk(0, "t6_start_ignored", 40);

        // Abort mid-row, then rerun on the surviving RAM contents
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("t3_rst");
        @(negedge clk);
        rst = 1'b0;
        mwd_a = '0;
        mwd_b = '0;
        idle_chk(0, "t3_no_finish", 40);
        run(0, 1'b0, "t3_rerun");

        repeat (3) begin
            for (int i = 0; i < 8; i++) put_w(0, i, 8'($urandom));
            for (int i = 0; i < 4; i++) put_d(0, i, 16'($urandom));
            run(0, 1'b0, "rnd_a");
        end

        // Full size: row2 sums to 0x00123400, other rows random
        for (int i = 0; i < 512; i++)
            put_w(1, i, (i >= 256 && i < 384) ? ((i == 256) ? 8'h40 : 8'h00) : 8'($urandom));
        for (int i = 0; i < 128; i++) put_d(1, i, (i == 0) ? 16'h48D0 : 16'($urandom));
        put_w(1, 69, 8'hA7);
        put_w(1, 255, 8'h5C);

        @(negedge clk);
        rd_para = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_dbg_off", 64'(rdo_b), 64'(wb[0]));
        rd_para = 1'b1; rd_bank = 2'd1; rd_wiener = 8'hC5;
        repeat (2) @(negedge clk);
        chk("t6_dbg69", 64'(rdo_b), 64'(wb[69]));
        rd_bank = 2'd3; rd_wiener = 8'h3F;
        repeat (2) @(negedge clk);
        chk("t6_dbg255", 64'(rdo_b), 64'(wb[255]));

        run(1, 1'b0, "t4");
        chk("t4_slot2", 64'(wd_b[47:32]), 64'h1234);
        rd_para = 1'b0;

        // Extremes: 0x7F * 0x7FFF and 0x7F * 0x8000 over 128 columns
        for (int i = 0; i < 512; i++) put_w(1, i, 8'h7F);
        for (int i = 0; i < 128; i++) put_d(1, i, 16'h7FFF);
        run(1, 1'b0, "t5_pos");
        chk("t5_pos_acc", 64'(first_acc), 64'h1FBF_C080);
        for (int i = 0; i < 128; i++) put_d(1, i, 16'h8000);
        run(1, 1'b0, "t5_neg");
        chk("t5_neg_acc", 64'(first_acc), 64'hE040_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
